mitchell_div: RTL

MITCHELL_DIV -- requirements
Module: mitchell_div

---
 rtl/mitchell_pkg.sv | 37 +++
 rtl/mitchell_log_enc.sv | 27 ++
 rtl/mitchell_div.sv | 119 +++++++++++
 3 files changed

// File: rtl/mitchell_pkg.sv
// Shared widths, constants and pipeline stage payloads for the Mitchell
// logarithmic divider.
package mitchell_pkg;

    localparam int OP_W      = 8;                    // operand magnitude width
    localparam int FRAC_W    = 7;                    // log fraction width
    localparam int EXP_W     = 3;                    // leading-one index width
    localparam int Q_W       = 16;                   // Q8.8 quotient width
    localparam int LOG_W     = EXP_W + FRAC_W + 1;   // signed log difference
    localparam int DBZ_CNT_W = 8;

    localparam logic [Q_W-1:0]       Q_SAT       = 16'hFFFF;
    localparam logic [DBZ_CNT_W-1:0] DBZ_CNT_MAX = '1;

    typedef struct packed {
        logic [EXP_W-1:0]  k;
        logic [FRAC_W-1:0] f;
    } log_t;

    typedef struct packed {
        logic valid;
        logic sign;
        logic x_zero;
        logic y_zero;
        log_t x_log;
        log_t y_log;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        logic             x_zero;
        logic             y_zero;
        logic [LOG_W-1:0] diff;
    } s2_t;

endpackage

// File: rtl/mitchell_log_enc.sv
// Mitchell log encoder: leading-one index k plus the bits below it,
// left-aligned into a FRAC_W-bit fraction.
module mitchell_log_enc
    import mitchell_pkg::*;
(
    input  logic [OP_W-1:0] mag,
    output log_t            log_val,
    output logic            zero
);

    logic [EXP_W-1:0] lead;
    logic [OP_W-1:0]  norm;

    always_comb begin
        // NOTE: every variable gets a default before the loop/branches so no
        // path leaves one unassigned and no latch is inferred.
        lead = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (mag[i]) lead = EXP_W'(i);
        end
        norm        = mag << (EXP_W'(OP_W - 1) - lead);
        log_val.k   = lead;
        log_val.f   = norm[FRAC_W-1:0];
        zero        = (mag == '0);
    end

endmodule

// File: rtl/mitchell_div.sv
// Three-stage Mitchell approximate divider (encode, subtract, antilog) with a
// valid/ready handshake and a saturating divide-by-zero counter.
module mitchell_div
    import mitchell_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [OP_W:0]        x_i,
    input  logic [OP_W:0]        y_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [Q_W-1:0]       q_o,
    output logic                 sign_o,
    output logic                 dbz_o,
    output logic [DBZ_CNT_W-1:0] dbz_count_o
);

    logic adv;
    log_t x_log, y_log;
    logic x_zero, y_zero;
    s1_t  s1_q;
    s2_t  s2_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv        = ~out_valid_o | out_ready_i;
    assign in_ready_o = adv;

    mitchell_log_enc u_enc_x (
        .mag     (x_i[OP_W-1:0]),
        .log_val (x_log),
        .zero    (x_zero)
    );

    mitchell_log_enc u_enc_y (
        .mag     (y_i[OP_W-1:0]),
        .log_val (y_log),
        .zero    (y_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so each stage captures its
        // predecessor's pre-edge value regardless of block ordering.
        if (rst_i) begin
            s1_q <= '0;
        end else if (adv) begin
            s1_q.valid  <= in_valid_i;
            s1_q.sign   <= x_i[OP_W] ^ y_i[OP_W];
            s1_q.x_zero <= x_zero;
            s1_q.y_zero <= y_zero;
            s1_q.x_log  <= x_log;
            s1_q.y_log  <= y_log;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_q <= '0;
        end else if (adv) begin
            s2_q.valid  <= s1_q.valid;
            s2_q.sign   <= s1_q.sign;
            s2_q.x_zero <= s1_q.x_zero;
            s2_q.y_zero <= s1_q.y_zero;
            s2_q.diff   <= {1'b0, s1_q.x_log} - {1'b0, s1_q.y_log};
        end
    end

    logic signed [EXP_W:0]   e;
    logic signed [EXP_W+1:0] sh;
    logic [FRAC_W:0]         m;
    logic [Q_W-1:0]          mag_q;
    logic [Q_W-1:0]          q_next;
    logic                    sign_next;
    logic                    dbz_next;

    // Antilog: 2^e * 1.F scaled to Q8.8, i.e. {1,F} shifted by e+1.
    always_comb begin
        e  = s2_q.diff[LOG_W-1:FRAC_W];
        m  = {1'b1, s2_q.diff[FRAC_W-1:0]};
        sh = $signed({e[EXP_W], e}) + 5'sd1;
        if (!sh[EXP_W+1]) mag_q = Q_W'(m) << sh[EXP_W:0];
        else              mag_q = Q_W'(m) >> (-sh);

        q_next    = mag_q;
        sign_next = s2_q.sign;
        dbz_next  = 1'b0;
        if (s2_q.y_zero) begin
            q_next   = Q_SAT;
            dbz_next = 1'b1;
        end else if (s2_q.x_zero) begin
            q_next    = '0;
            sign_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            q_o         <= '0;
            sign_o      <= 1'b0;
            dbz_o       <= 1'b0;
        end else if (adv) begin
            out_valid_o <= s2_q.valid;
            q_o         <= q_next;
            sign_o      <= sign_next;
            dbz_o       <= dbz_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dbz_count_o <= '0;
        end else if (out_valid_o && out_ready_i && dbz_o && dbz_count_o != DBZ_CNT_MAX) begin
            dbz_count_o <= dbz_count_o + 1'b1;
        end
    end

endmodule
